// File: rtl/cache_cmd_arbiter.sv
// Arbitrates L1 and bus-snoop command queues onto a single cache command port.
// Snoops have priority, bounded by a streak limit; an L1 clear waits until no snoops remain.

module cache_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 36
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
        if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module cache_cmd_arbiter #(
    parameter int DEPTH          = 4,
    parameter int OP_CYCLES      = 3,
    parameter int MAX_SNP_STREAK = 4
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        l1_req_valid,
    input  logic [3:0]  l1_req_n,
    input  logic [31:0] l1_req_addr,
    output logic        l1_req_ready,
    input  logic        snp_req_valid,
    input  logic [3:0]  snp_req_n,
    input  logic [31:0] snp_req_addr,
    output logic        snp_req_ready,
    output logic        cache_valid,
    output logic [3:0]  cache_n,
    output logic [31:0] cache_address,
    output logic        grant_src,
    output logic        busy,
    output logic [15:0] issued_cntr,
    output logic [7:0]  bad_cmd_cntr
);
    localparam int CW = $clog2(OP_CYCLES) + 1;
    localparam int SW = $clog2(MAX_SNP_STREAK + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q;
    logic          cv_q, src_q, busy_q;
    logic [3:0]    n_q;
    logic [31:0]   addr_q;
    logic [15:0]   issued_q;
    logic [7:0]    bad_q, bad_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [CW-1:0] wait_q;

    logic        l1_full, l1_empty, snp_full, snp_empty;
    logic [35:0] l1_head, snp_head;
    logic        l1_acc, snp_acc, l1_legal, snp_legal;
    logic        l1_push, snp_push, l1_bad, snp_bad;
    logic        l1_elig, snp_elig, pick_snp, grant, l1_pop, snp_pop;
    logic [8:0]  bad_sum;

    assign l1_req_ready  = ~l1_full;
    assign snp_req_ready = ~snp_full;

    assign l1_acc    = l1_req_valid & l1_req_ready;
    assign snp_acc   = snp_req_valid & snp_req_ready;
    assign l1_legal  = l1_req_n inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    assign snp_legal = snp_req_n inside {4'd3, 4'd4, 4'd5, 4'd6};
    assign l1_push   = l1_acc & l1_legal;
    assign snp_push  = snp_acc & snp_legal;
    assign l1_bad    = l1_acc & ~l1_legal;
    assign snp_bad   = snp_acc & ~snp_legal;

    cache_cmd_fifo #(.DEPTH(DEPTH), .DW(36)) u_l1_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (l1_push),
        .din_i   ({l1_req_n, l1_req_addr}),
        .pop_i   (l1_pop),
        .dout_o  (l1_head),
        .full_o  (l1_full),
        .empty_o (l1_empty)
    );

    cache_cmd_fifo #(.DEPTH(DEPTH), .DW(36)) u_snp_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (snp_push),
        .din_i   ({snp_req_n, snp_req_addr}),
        .pop_i   (snp_pop),
        .dout_o  (snp_head),
        .full_o  (snp_full),
        .empty_o (snp_empty)
    );

    // A clear must not overtake any snoop, including one landing this cycle.
    assign l1_elig  = ~l1_empty & ((l1_head[35:32] != 4'd8) | (snp_empty & ~snp_push));
    assign snp_elig = ~snp_empty;
    assign pick_snp = snp_elig & (~l1_elig | (streak_q != SW'(MAX_SNP_STREAK)));
    assign grant    = (state_q == IDLE) & (snp_elig | l1_elig);
    assign l1_pop   = grant & ~pick_snp;
    assign snp_pop  = grant & pick_snp;

    assign bad_sum = {1'b0, bad_q} + 9'(l1_bad) + 9'(snp_bad);
    assign bad_d   = bad_sum[8] ? 8'hFF : bad_sum[7:0];

    // Streak saturates so a long clear stall cannot wrap it below the limit.
    always_comb begin
        streak_d = '0;
        if (pick_snp && !l1_empty)
            streak_d = (streak_q == SW'(MAX_SNP_STREAK)) ? streak_q : streak_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q  <= IDLE;
            cv_q     <= 1'b0;
            n_q      <= '0;
            addr_q   <= '0;
            src_q    <= 1'b0;
            busy_q   <= 1'b0;
            issued_q <= '0;
            bad_q    <= '0;
            streak_q <= '0;
            wait_q   <= '0;
        end else begin
            bad_q <= bad_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q  <= ISSUE;
                        cv_q     <= 1'b1;
                        busy_q   <= 1'b1;
                        n_q      <= pick_snp ? snp_head[35:32] : l1_head[35:32];
                        addr_q   <= pick_snp ? snp_head[31:0]  : l1_head[31:0];
                        src_q    <= pick_snp;
                        streak_q <= streak_d;
                    end
                end
                ISSUE: begin
                    state_q  <= WAIT;
                    cv_q     <= 1'b0;
                    issued_q <= issued_q + 1'b1;
                    wait_q   <= CW'(OP_CYCLES - 1);
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cv_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cache_valid   = cv_q;
    assign cache_n       = n_q;
    assign cache_address = addr_q;
    assign grant_src     = src_q;
    assign busy          = busy_q;
    assign issued_cntr   = issued_q;
    assign bad_cmd_cntr  = bad_q;
endmodule

// File: tb/tb_cache_cmd_arbiter.sv
// Directed bench for cache_cmd_arbiter with default parameters (DEPTH=4, OP_CYCLES=3, streak 4).
module tb_cache_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        l1_req_valid = 1'b0, snp_req_valid = 1'b0;
    logic [3:0]  l1_req_n = '0, snp_req_n = '0;
    logic [31:0] l1_req_addr = '0, snp_req_addr = '0;
    logic        l1_req_ready, snp_req_ready;
    logic        cache_valid, grant_src, busy;
    logic [3:0]  cache_n;
    logic [31:0] cache_address;
    logic [15:0] issued_cntr;
    logic [7:0]  bad_cmd_cntr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int          pcyc[$];
    logic        psrc[$];
    logic [3:0]  pn[$];
    logic [31:0] paddr[$];

    always #5 clk = ~clk;

    cache_cmd_arbiter dut (
        .clk(clk), .rstb(rstb),
        .l1_req_valid(l1_req_valid), .l1_req_n(l1_req_n), .l1_req_addr(l1_req_addr),
        .l1_req_ready(l1_req_ready),
        .snp_req_valid(snp_req_valid), .snp_req_n(snp_req_n), .snp_req_addr(snp_req_addr),
        .snp_req_ready(snp_req_ready),
        .cache_valid(cache_valid), .cache_n(cache_n), .cache_address(cache_address),
        .grant_src(grant_src), .busy(busy), .issued_cntr(issued_cntr),
        .bad_cmd_cntr(bad_cmd_cntr)
    );

    // Log of every issued command, sampled at the edge that ends its strobe cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cache_valid) begin
            pcyc.push_back(cyc);
            psrc.push_back(grant_src);
            pn.push_back(cache_n);
            paddr.push_back(cache_address);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int k = 0;
        while (pcyc.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("pulse_timeout", pcyc.size(), target);
    endtask

    task automatic do_reset();
        rstb = 1'b1;
        step(1);
        chk("rst_cv", cache_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issued", issued_cntr, 0);
        rstb = 1'b0;
        step(1);
        chk("rst_l1_rdy", l1_req_ready, 1);
        chk("rst_snp_rdy", snp_req_ready, 1);
    endtask

    int base;

    initial begin
        // Reset state
        step(2);
        chk("r0_cv", cache_valid, 0);
        chk("r0_n", cache_n, 0);
        chk("r0_addr", cache_address, 0);
        chk("r0_src", grant_src, 0);
        chk("r0_busy", busy, 0);
        chk("r0_issued", issued_cntr, 0);
        chk("r0_bad", bad_cmd_cntr, 0);
        rstb = 1'b0;
        step(1);
        chk("r0_l1_rdy", l1_req_ready, 1);
        chk("r0_snp_rdy", snp_req_ready, 1);

        // Single L1 read: strobe two edges after acceptance, busy for 4 cycles
        l1_req_valid = 1'b1; l1_req_n = 4'd0; l1_req_addr = 32'h1000_0040;
        step(1);
        l1_req_valid = 1'b0;
        chk("rd_cv_early", cache_valid, 0);
        chk("rd_busy_early", busy, 0);
        step(1);
        chk("rd_cv", cache_valid, 1);
        chk("rd_n", cache_n, 0);
        chk("rd_addr", cache_address, 32'h1000_0040);
        chk("rd_src", grant_src, 0);
        chk("rd_busy1", busy, 1);
        step(1);
        chk("rd_cv_off", cache_valid, 0);
        chk("rd_issued", issued_cntr, 1);
        chk("rd_busy2", busy, 1);
        step(1);
        chk("rd_busy3", busy, 1);
        step(1);
        chk("rd_busy4", busy, 1);
        step(1);
        chk("rd_busy_end", busy, 0);
        chk("rd_addr_hold", cache_address, 32'h1000_0040);

        // Illegal codes on both sides in the same cycle
        base = pcyc.size();
        l1_req_valid = 1'b1; l1_req_n = 4'd3;
        snp_req_valid = 1'b1; snp_req_n = 4'd0;
        step(1);
        l1_req_valid = 1'b0; snp_req_valid = 1'b0;
        chk("bad2", bad_cmd_cntr, 2);
        step(5);
        chk("bad_no_pulse", pcyc.size(), base);
        chk("bad_busy", busy, 0);

        // Clear waits behind two snoops
        base = pcyc.size();
        snp_req_valid = 1'b1; snp_req_n = 4'd3; snp_req_addr = 32'hA000_0001;
        l1_req_valid = 1'b1; l1_req_n = 4'd8; l1_req_addr = 32'hC000_0000;
        step(1);
        snp_req_n = 4'd4; snp_req_addr = 32'hA000_0002;
        l1_req_valid = 1'b0;
        step(1);
        snp_req_valid = 1'b0;
        wait_pulses(base + 3, 40);
        if (pcyc.size() >= base + 3) begin
            chk("clr_src0", psrc[base], 1);
            chk("clr_n0", pn[base], 3);
            chk("clr_a0", paddr[base], 32'hA000_0001);
            chk("clr_src1", psrc[base+1], 1);
            chk("clr_n1", pn[base+1], 4);
            chk("clr_src2", psrc[base+2], 0);
            chk("clr_n2", pn[base+2], 8);
            chk("clr_a2", paddr[base+2], 32'hC000_0000);
        end
        step(6);
        chk("clr_n_hold", cache_n, 8);

        // Both queues kept full: S,S,S,S,L with 5-cycle spacing
        base = pcyc.size();
        l1_req_valid = 1'b1; l1_req_n = 4'd1; l1_req_addr = 32'h0000_1111;
        snp_req_valid = 1'b1; snp_req_n = 4'd5; snp_req_addr = 32'h0000_2222;
        wait_pulses(base + 10, 120);
        l1_req_valid = 1'b0; snp_req_valid = 1'b0;
        if (pcyc.size() >= base + 10) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("pat_src%0d", i), psrc[base+i], (i % 5 == 4) ? 0 : 1);
            for (int i = 0; i < 9; i++)
                chk($sformatf("pat_gap%0d", i), pcyc[base+i+1] - pcyc[base+i], 5);
        end
        do_reset();

        // Five L1 clears while snoops stream: queue fills after 4, 5th refused
        base = pcyc.size();
        l1_req_valid = 1'b1; l1_req_n = 4'd8;
        snp_req_valid = 1'b1; snp_req_n = 4'd6; snp_req_addr = 32'h0000_3333;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_rdy%0d", i), l1_req_ready, 1);
            l1_req_addr = 32'h2000 + i;
            step(1);
        end
        chk("full_rdy_lo", l1_req_ready, 0);
        l1_req_addr = 32'h2004;
        step(1);
        chk("full_rdy_hold", l1_req_ready, 0);
        step(10);
        chk("full_rdy_stay", l1_req_ready, 0);
        l1_req_valid = 1'b0; snp_req_valid = 1'b0;
        for (int i = base; i < pcyc.size(); i++)
            chk($sformatf("full_snp_only%0d", i - base), psrc[i], 1);
        do_reset();

        // Reset during WAIT with 3 entries queued
        l1_req_valid = 1'b1; l1_req_n = 4'd0;
        for (int i = 0; i < 4; i++) begin
            l1_req_addr = 32'h100 + i;
            step(1);
        end
        l1_req_valid = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_cv", cache_valid, 0);
        chk("mid_issued", issued_cntr, 1);
        rstb = 1'b1;
        step(1);
        rstb = 1'b0;
        chk("mid_rst_cv", cache_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_issued", issued_cntr, 0);
        chk("mid_rst_l1rdy", l1_req_ready, 1);
        chk("mid_rst_snprdy", snp_req_ready, 1);
        base = pcyc.size();
        step(20);
        chk("mid_no_pulse", pcyc.size(), base);
        chk("mid_issued_end", issued_cntr, 0);

        // Bad counter saturates at 255
        l1_req_valid = 1'b1; l1_req_n = 4'd5;
        snp_req_valid = 1'b1; snp_req_n = 4'd9;
        step(1);
        chk("sat_2", bad_cmd_cntr, 2);
        step(126);
        chk("sat_254", bad_cmd_cntr, 254);
        step(1);
        chk("sat_255", bad_cmd_cntr, 255);
        step(3);
        l1_req_valid = 1'b0; snp_req_valid = 1'b0;
        step(2);
        chk("sat_hold", bad_cmd_cntr, 255);
        chk("sat_no_pulse", pcyc.size(), base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
